// File: rtl/alu_seq_top.sv
// Board wrapper around the combinational alu core: debounced buttons drive an
// A -> B -> Op -> execute load sequencer with registered result, flags and chaining.

module alu #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [OP_WIDTH-1:0]   i_op,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_negative,
  output logic                  o_zero,
  output logic                  o_carry
);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(6'b100000);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(6'b100010);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(6'b100100);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(6'b100101);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(6'b100110);
  localparam logic [OP_WIDTH-1:0] OP_NOR = OP_WIDTH'(6'b100111);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;

  assign sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the extended difference is the borrow, reported as carry on SUB.
  assign diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = sum[DATA_WIDTH-1:0];
        o_carry  = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        o_result = diff[DATA_WIDTH-1:0];
        o_carry  = diff[DATA_WIDTH];
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      default: o_result = '0;
    endcase
  end

  assign o_negative = o_result[DATA_WIDTH-1];
  assign o_zero     = (o_result == '0);
endmodule

module alu_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          deb_q;
  logic          deb_d;
  logic          deb_prev_q;
  logic          pulse_q;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      sync1_q    <= i_btn;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      pulse_q    <= deb_q & ~deb_prev_q;
    end
  end

  assign o_pulse = pulse_q;
endmodule

module alu_seq_top #(
  parameter int DATA_WIDTH      = 8,
  parameter int OP_WIDTH        = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_sw,
  input  logic [2:0]            i_btn,
  output logic [DATA_WIDTH-1:0] o_led,
  output logic [2:0]            o_flags,
  output logic [3:0]            o_state,
  output logic                  o_valid
);
  typedef enum logic [2:0] {ST_A, ST_B, ST_OP, ST_EXEC, ST_RES} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] reg_a_q, reg_a_d;
  logic [DATA_WIDTH-1:0] reg_b_q, reg_b_d;
  logic [OP_WIDTH-1:0]   reg_op_q, reg_op_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [2:0]            flags_q, flags_d;

  logic [2:0]            pulse;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_neg;
  logic                  alu_zero;
  logic                  alu_carry;

  for (genvar g = 0; g < 3; g++) begin : g_btn
    alu_btn_cond #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_btn  (i_btn[g]),
      .o_pulse(pulse[g])
    );
  end

  alu #(
    .DATA_WIDTH(DATA_WIDTH),
    .OP_WIDTH  (OP_WIDTH)
  ) u_alu (
    .i_a       (reg_a_q),
    .i_b       (reg_b_q),
    .i_op      (reg_op_q),
    .o_result  (alu_result),
    .o_negative(alu_neg),
    .o_zero    (alu_zero),
    .o_carry   (alu_carry)
  );

  always_comb begin
    state_d  = state_q;
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    reg_op_d = reg_op_q;
    result_d = result_q;
    flags_d  = flags_q;
    // Clear outranks everything, EXEC included; enter outranks chain.
    if (pulse[2]) begin
      state_d  = ST_A;
      reg_a_d  = '0;
      reg_b_d  = '0;
      reg_op_d = '0;
      result_d = '0;
      flags_d  = '0;
    end else begin
      case (state_q)
        ST_A: if (pulse[0]) begin
          reg_a_d = i_sw;
          state_d = ST_B;
        end
        ST_B: if (pulse[0]) begin
          reg_b_d = i_sw;
          state_d = ST_OP;
        end
        ST_OP: if (pulse[0]) begin
          reg_op_d = i_sw[OP_WIDTH-1:0];
          state_d  = ST_EXEC;
        end
        ST_EXEC: begin
          result_d = alu_result;
          flags_d  = {alu_neg, alu_zero, alu_carry};
          state_d  = ST_RES;
        end
        ST_RES: begin
          if (pulse[0]) begin
            state_d = ST_A;
          end else if (pulse[1]) begin
            reg_a_d = result_q;
            state_d = ST_B;
          end
        end
        default: state_d = ST_A;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_A;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      reg_op_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      reg_op_q <= reg_op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    o_state = 4'b0000;
    case (state_q)
      ST_A:    o_state = 4'b0001;
      ST_B:    o_state = 4'b0010;
      ST_OP:   o_state = 4'b0100;
      ST_RES:  o_state = 4'b1000;
      default: o_state = 4'b0000;
    endcase
  end

  assign o_led   = result_q;
  assign o_flags = flags_q;
  assign o_valid = (state_q == ST_RES);
endmodule

// File: tb/tb_alu_seq_top.sv
// Randomized button-press bench for alu_seq_top with a transaction-level reference model
// (press of >= DEBOUNCE_CYCLES lands DEBOUNCE_CYCLES+4 edges later) checked every cycle.

module tb_alu_seq_top;
  localparam int D   = 4;
  localparam int LAT = D + 4;
  localparam int GAP = D + 6;

  localparam int PH_A = 0, PH_B = 1, PH_OP = 2, PH_EXEC = 3, PH_RES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = '0;
  logic [2:0] btn = '0;
  logic [7:0] led;
  logic [2:0] flags;
  logic [3:0] state;
  logic       valid;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  int         ph = PH_A;
  logic [7:0] m_a = '0, m_b = '0, m_r = '0;
  logic [5:0] m_op = '0;
  logic [2:0] m_f = '0;
  bit [2:0]   pend[int];

  int t0 = 0;
  int rel = 0;

  alu_seq_top #(
    .DATA_WIDTH     (8),
    .OP_WIDTH       (6),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_sw   (sw),
    .i_btn  (btn),
    .o_led  (led),
    .o_flags(flags),
    .o_state(state),
    .o_valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_state(input int p);
    case (p)
      PH_A:    return 4'b0001;
      PH_B:    return 4'b0010;
      PH_OP:   return 4'b0100;
      PH_RES:  return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                           output logic [7:0] r, output logic [2:0] f);
    int s;
    logic c;
    c = 1'b0;
    case (op)
      6'h20: begin s = int'(a) + int'(b); r = s[7:0]; c = (s > 255); end
      6'h22: begin r = a - b; c = (a < b); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      default: r = 8'h00;
    endcase
    f = {r[7], r == 8'h00, c};
  endtask

  task automatic model_reset();
    ph = PH_A; m_a = '0; m_b = '0; m_op = '0; m_r = '0; m_f = '0;
    pend.delete();
  endtask

  task automatic model_step(input bit [2:0] p);
    if (p[2]) begin
      ph = PH_A; m_a = '0; m_b = '0; m_op = '0; m_r = '0; m_f = '0;
    end else begin
      case (ph)
        PH_A:    if (p[0]) begin m_a = sw; ph = PH_B; end
        PH_B:    if (p[0]) begin m_b = sw; ph = PH_OP; end
        PH_OP:   if (p[0]) begin m_op = sw[5:0]; ph = PH_EXEC; end
        PH_EXEC: begin model_alu(m_a, m_b, m_op, m_r, m_f); ph = PH_RES; end
        default: begin
          if (p[0]) ph = PH_A;
          else if (p[1]) begin m_a = m_r; ph = PH_B; end
        end
      endcase
    end
  endtask

  // Reference model advance on each edge, comparison on the following falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        cyc++;
        if (pend.exists(cyc)) begin
          model_step(pend[cyc]);
          pend.delete(cyc);
        end else begin
          model_step(3'b000);
        end
      end
      @(negedge clk);
      if (chk_en) begin
        check("cyc_led", 32'(led), 32'(m_r));
        check("cyc_flags", 32'(flags), 32'(m_f));
        check("cyc_state", 32'(state), 32'(exp_state(ph)));
        check("cyc_valid", 32'(valid), 32'(ph == PH_RES));
      end
    end
  end

  task automatic start(input bit [2:0] mask, input logic [7:0] sw_v, input int h);
    @(posedge clk);
    #1;
    t0 = cyc;
    rel = cyc + h;
    sw = sw_v;
    btn = mask;
    if (h >= D) pend[cyc + LAT] = mask;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      if (cyc >= rel) btn = '0;
    end
  endtask

  task automatic press(input bit [2:0] mask, input logic [7:0] sw_v, input int h);
    start(mask, sw_v, h);
    run_to(t0 + h + GAP);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] v;
    repeat (3) @(posedge clk);
    #2;
    check("rst_state", 32'(state), 32'h1);
    check("rst_led", 32'(led), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);

    // Short glitch is filtered
    press(3'b001, 8'h55, 3);
    check("glitch_state", 32'(state), 32'h1);

    // Long hold: exactly one action, landing 8 edges after the press
    start(3'b001, 8'h05, 20);
    run_to(t0 + 7);
    check("lat_before", 32'(state), 32'h1);
    run_to(t0 + 8);
    check("lat_after", 32'(state), 32'h2);
    run_to(t0 + 20 + GAP);
    check("hold_once", 32'(state), 32'h2);

    press(3'b001, 8'h03, D + 1);
    start(3'b001, 8'h20, D + 2);
    run_to(t0 + 8);
    check("exec_state", 32'(state), 32'h0);
    check("exec_valid", 32'(valid), 32'h0);
    run_to(t0 + 9);
    check("res_valid", 32'(valid), 32'h1);
    run_to(t0 + D + 2 + GAP);
    check("add_led", 32'(led), 32'h08);
    check("add_flags", 32'(flags), 32'h0);

    // Chain: result becomes A, straight to B
    press(3'b010, 8'hEE, D);
    check("chain_state", 32'(state), 32'h2);
    press(3'b001, 8'h02, D);
    press(3'b001, 8'h20, D);
    check("chain_led", 32'(led), 32'h0A);

    press(3'b001, 8'h00, D);
    check("hold_led", 32'(led), 32'h0A);
    press(3'b001, 8'h33, D);
    check("inB_state", 32'(state), 32'h2);

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #0.5;
    check("arst_state", 32'(state), 32'h1);
    check("arst_led", 32'(led), 32'h0);
    model_reset();
    #0.5;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    press(3'b001, 8'hFF, D);
    press(3'b001, 8'h01, D);
    press(3'b001, 8'h20, D);
    check("wrap_led", 32'(led), 32'h00);
    check("wrap_flags", 32'(flags), 32'h3);

    // Clear and enter together in OP
    press(3'b001, 8'h00, D);
    press(3'b001, 8'h07, D);
    press(3'b001, 8'h09, D);
    check("inOP_state", 32'(state), 32'h4);
    press(3'b101, 8'h20, D);
    check("clr_state", 32'(state), 32'h1);
    check("clr_led", 32'(led), 32'h0);
    check("clr_flags", 32'(flags), 32'h0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      v = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 5))
          0: v[5:0] = 6'h20;
          1: v[5:0] = 6'h22;
          2: v[5:0] = 6'h24;
          3: v[5:0] = 6'h25;
          4: v[5:0] = 6'h26;
          default: v[5:0] = 6'h27;
        endcase
      end
      if (r < 55)      press(3'b001, v, $urandom_range(D, D + 8));
      else if (r < 70) press(3'b010, v, $urandom_range(D, D + 8));
      else if (r < 78) press(3'b100, v, $urandom_range(D, D + 8));
      else if (r < 90) press(3'($urandom_range(1, 7)), v, $urandom_range(1, D - 1));
      else             press(3'($urandom_range(1, 7)), v, $urandom_range(D, D + 8));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq_top.md
Name: alu_seq_top

Overview:
- Board-level wrapper around the team's combinational alu core (ports i_a, i_b, i_op, o_result, o_negative, o_zero, o_carry). It replaces direct per-operand load buttons with debounced, edge-detected buttons.
- A single "enter" button drives a load sequencer FSM: A, then B, then Op, then execute.
- The result and flags are registered. A chain mode feeds the result back as operand A for accumulator-style calculations.

Parameters:
- DATA_WIDTH, 8, operand/result width; must be >= OP_WIDTH.
- OP_WIDTH, 6, opcode width passed to the alu core.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change; minimum 1.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_sw  input  DATA_WIDTH  switch value sampled on load.
- i_btn  input  3  raw buttons: [0] enter, [1] chain, [2] clear.
- o_led  output  DATA_WIDTH  registered result.
- o_flags  output  3  registered {negative, zero, carry}.
- o_state  output  4  one-hot FSM indicator: {RES, OP, B, A}; EXEC shows as 4'b0000.
- o_valid  output  1  high while state is RES.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state=A; reg_A, reg_B, reg_Op, result=0; flags=0.
  - o_state=4'b0001, o_valid=0.
  - Debounced levels=0, counters=0, synchronisers=0.
  - Reset wins over everything, mid-operation included.
- Button conditioning, per button, independent:
  - 2-FF synchroniser.
  - Counter counts consecutive cycles in which the synchronised level differs from the debounced level; it clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces a 1-cycle pulse on the next cycle.
  - Falling edges produce no pulse. Holding a button produces exactly one pulse.
- Pulse priority in the same cycle: clear > enter > chain; lower-priority pulses are dropped.
- FSM states: A, B, OP, EXEC, RES.
  - A: enter -> reg_A<=i_sw, go to B.
  - B: enter -> reg_B<=i_sw, go to OP.
  - OP: enter -> reg_Op<=i_sw[OP_WIDTH-1:0], go to EXEC.
  - EXEC, exactly 1 cycle, no inputs honoured: result<=alu o_result; flags<={o_negative,o_zero,o_carry}; go to RES.
  - RES: enter -> go to A, registers retained. chain -> reg_A<=result, go to B.
  - Any state: clear -> reg_A, reg_B, reg_Op, result, flags = 0; go to A.
  - chain outside RES is ignored.
- Outputs:
  - o_led and o_flags change only in the EXEC->RES transition, on clear, or on reset. They hold the last result while new operands are entered.
  - o_valid=1 exactly in RES.
- Latency:
  - Raw press to pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
  - Op-load pulse to o_valid: 2 cycles (OP->EXEC, EXEC->RES).
- Arithmetic, width and encoding:
  - All ALU semantics come from the alu core with DATA_WIDTH/OP_WIDTH passed through.
  - Opcode encodings used: ADD 6'b100000, SUB 6'b100010, AND 6'b100100.
  - No width extension; the result is truncated to DATA_WIDTH by the core.

Test Plan (DEBOUNCE_CYCLES=4, DATA_WIDTH=8, OP_WIDTH=6):
- Basic add: enter with sw=0x05, enter 0x03, enter 0x20 (ADD) -> o_led=0x08, o_flags=3'b000, o_valid=1. o_valid rises 2 cycles after the third enter pulse.
- Wrap and flags: A=0xFF, B=0x01, ADD -> o_led=0x00, o_flags=3'b011 (zero, carry).
- Chain: after result 0x08, press chain, then B=0x02, Op=ADD -> o_led=0x0A; reg_A was loaded with 0x08 and the state went to B directly.
- Debounce: raw enter high for 3 cycles, then low -> no pulse, state stays A. Raw enter high for 20 cycles -> exactly one pulse, pulse at cycle 2+4+1=7 after the press.
- Clear and priority: in OP, press clear and enter in the same cycle -> state=A, o_led=0x00, o_flags=0, reg_Op unchanged at 0.
- Async reset mid-sequence: i_rst_n low for 1 ns while in B, between clock edges -> o_state=4'b0001 and o_led=0x00 immediately, without waiting for a clock edge.
